// File: rtl/call_station_arbiter.sv
// call_station_arbiter: shares one attendant between N_STATIONS call buttons.
// Each station has a latched call light. A round-robin scheduler offers the
// pending lights to the attendant one at a time, then waits for ack and done.
// An offer left unanswered for TIMEOUT cycles pulses escalate, and keeps
// pulsing every TIMEOUT cycles until it is answered or withdrawn.
module call_station_arbiter #(
  parameter int N_STATIONS = 4,
  parameter int ID_W       = 2,
  parameter int TIMEOUT    = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N_STATIONS-1:0] call,
  input  logic [N_STATIONS-1:0] cancel,
  input  logic                  ack,
  input  logic                  done,
  output logic [N_STATIONS-1:0] pending,
  output logic                  grant_valid,
  output logic [ID_W-1:0]       grant_id,
  output logic                  busy,
  output logic                  escalate
);

  localparam int CNT_W = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE,
    OFFER,
    SERVE
  } state_t;

  state_t                  state;
  logic [ID_W-1:0]         last;
  logic [CNT_W-1:0]        wait_cnt;
  logic [N_STATIONS-1:0]   clr;
  logic [N_STATIONS-1:0]   pending_next;
  logic [ID_W-1:0]         next_id;
  logic                    next_found;
  int                      scan_idx;

  // Round-robin scan: first lit station after the last one served, wrapping.
  always_comb begin
    next_id    = '0;
    next_found = 1'b0;
    scan_idx   = 0;
    for (int k = 1; k <= N_STATIONS; k++) begin
      scan_idx = int'(last) + k;
      if (scan_idx >= N_STATIONS) begin
        scan_idx = scan_idx - N_STATIONS;
      end
      if (!next_found && pending[scan_idx]) begin
        next_found = 1'b1;
        next_id    = ID_W'(scan_idx);
      end
    end
  end

  // Light update: a fresh call wins over cancel and over completed service.
  always_comb begin
    clr = '0;
    for (int i = 0; i < N_STATIONS; i++) begin
      clr[i] = (state == SERVE) && done && (grant_id == ID_W'(i));
    end
    pending_next = call | (pending & ~cancel & ~clr);
  end

  // Call lights register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending <= '0;
    end else begin
      pending <= pending_next;
    end
  end

  // Offer/serve scheduler with registered grant, busy and escalate outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      grant_valid <= 1'b0;
      grant_id    <= '0;
      busy        <= 1'b0;
      escalate    <= 1'b0;
      wait_cnt    <= '0;
      last        <= ID_W'(N_STATIONS - 1);
    end else begin
      escalate <= 1'b0;
      unique case (state)
        IDLE: begin
          if (next_found) begin
            grant_id    <= next_id;
            wait_cnt    <= '0;
            grant_valid <= 1'b1;
            state       <= OFFER;
          end
        end
        OFFER: begin
          if (!pending[grant_id]) begin
            grant_valid <= 1'b0;
            state       <= IDLE;
          end else if (ack) begin
            grant_valid <= 1'b0;
            busy        <= 1'b1;
            state       <= SERVE;
          end else if (wait_cnt == WAIT_LAST) begin
            wait_cnt <= '0;
            escalate <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        SERVE: begin
          if (done) begin
            last  <= grant_id;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: begin
          grant_valid <= 1'b0;
          busy        <= 1'b0;
          state       <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_call_station_arbiter.sv
// tb_call_station_arbiter: drives directed and random traffic into
// call_station_arbiter, predicts every cycle's outputs with a behavioural
// model, and compares them through a queue drained by an independent monitor.
module tb_call_station_arbiter;

  localparam int N_S  = 4;
  localparam int ID_W = 2;
  localparam int TO   = 16;

  localparam int M_IDLE  = 0;
  localparam int M_OFFER = 1;
  localparam int M_SERVE = 2;

  typedef logic [N_S+ID_W+2:0] vec_t;

  logic           clk    = 1'b0;
  logic           rst_n  = 1'b1;
  logic [N_S-1:0] call   = '0;
  logic [N_S-1:0] cancel = '0;
  logic           ack    = 1'b0;
  logic           done   = 1'b0;
  logic [N_S-1:0] pending;
  logic           grant_valid;
  logic [ID_W-1:0] grant_id;
  logic           busy;
  logic           escalate;

  int   n_vec  = 0;
  int   n_miss = 0;
  vec_t exp_q[$];

  // Behavioural model state: lights, what the attendant is doing, and who.
  logic [N_S-1:0] m_pend;
  int             m_mode;
  int             m_sel;
  int             m_last;
  int             m_age;
  logic           m_esc;

  call_station_arbiter #(
    .N_STATIONS(N_S),
    .ID_W      (ID_W),
    .TIMEOUT   (TO)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .call       (call),
    .cancel     (cancel),
    .ack        (ack),
    .done       (done),
    .pending    (pending),
    .grant_valid(grant_valid),
    .grant_id   (grant_id),
    .busy       (busy),
    .escalate   (escalate)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  function automatic vec_t dutVec();
    return {pending, grant_valid, grant_id, busy, escalate};
  endfunction

  function automatic vec_t expVec();
    return {m_pend, (m_mode == M_OFFER), ID_W'(m_sel), (m_mode == M_SERVE), m_esc};
  endfunction

  function automatic int nextStation(input logic [N_S-1:0] lights, input int after);
    for (int k = 1; k <= N_S; k++) begin
      if (lights[(after + k) % N_S]) return (after + k) % N_S;
    end
    return -1;
  endfunction

  task automatic checkOutput(input string name, input int actual, input int required);
    n_vec++;
    if (actual !== required) begin
      n_miss++;
      $display("[TB] FAIL %s: got 0x%0h, required 0x%0h at %0t", name, actual, required, $time);
    end
  endtask

  task automatic modelReset();
    m_pend = '0;
    m_mode = M_IDLE;
    m_sel  = 0;
    m_last = N_S - 1;
    m_age  = 0;
    m_esc  = 1'b0;
  endtask

  // Advance the model by one clock given the inputs presented for that clock.
  task automatic modelStep(input logic [N_S-1:0] c, input logic [N_S-1:0] x,
                           input logic a, input logic d);
    logic [N_S-1:0] np;
    int nmode, nsel, nlast, nage;
    logic nesc;
    np    = c | (m_pend & ~x);
    nmode = m_mode;
    nsel  = m_sel;
    nlast = m_last;
    nage  = m_age;
    nesc  = 1'b0;
    if (m_mode == M_SERVE && d) np[m_sel] = c[m_sel];
    if (m_mode == M_IDLE) begin
      if (m_pend != '0) begin
        nsel  = nextStation(m_pend, m_last);
        nmode = M_OFFER;
        nage  = 0;
      end
    end else if (m_mode == M_OFFER) begin
      if (!m_pend[m_sel]) nmode = M_IDLE;
      else if (a) nmode = M_SERVE;
      else begin
        nage = m_age + 1;
        nesc = ((nage % TO) == 0);
      end
    end else begin
      if (d) begin
        nlast = m_sel;
        nmode = M_IDLE;
      end
    end
    m_pend = np;
    m_mode = nmode;
    m_sel  = nsel;
    m_last = nlast;
    m_age  = nage;
    m_esc  = nesc;
  endtask

  // Present one cycle of inputs, predict the result, and queue the prediction.
  task automatic applyStimulus(input logic [N_S-1:0] c, input logic [N_S-1:0] x,
                               input logic a, input logic d);
    call   = c;
    cancel = x;
    ack    = a;
    done   = d;
    modelStep(c, x, a, d);
    @(posedge clk);
    exp_q.push_back(expVec());
    #1;
  endtask

  // Asynchronous reset pulse between clock edges; outputs must clear at once.
  task automatic doReset();
    @(negedge clk);
    #2;
    exp_q.delete();
    call   = '0;
    cancel = '0;
    ack    = 1'b0;
    done   = 1'b0;
    rst_n  = 1'b0;
    #1;
    checkOutput("async_reset_outputs", int'(dutVec()), 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    modelReset();
  endtask

  // Hold the given lights, ack every offer and finish every service, and
  // compare the order of offered stations against the expected rotation.
  task automatic runRotation(input logic [N_S-1:0] held, input int exp_ids[5],
                             input int n, input string name);
    int got[$];
    logic prev_gv;
    int budget;
    prev_gv = 1'b0;
    budget  = 0;
    while (got.size() < n && budget < 80) begin
      if (grant_valid && !prev_gv) got.push_back(int'(grant_id));
      prev_gv = grant_valid;
      applyStimulus(held, '0, grant_valid, busy);
      budget++;
    end
    for (int i = 0; i < n; i++) begin
      if (i < got.size()) checkOutput($sformatf("%s_grant%0d", name, i), got[i], exp_ids[i]);
      else checkOutput($sformatf("%s_grant%0d_missing", name, i), -1, exp_ids[i]);
    end
  endtask

  // Scoreboard monitor: compares each predicted cycle against the DUT.
  initial begin
    vec_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checkOutput("cycle_outputs", int'(dutVec()), int'(e));
      end
    end
  end

  // Guard against a hung run.
  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got timeout, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Main stimulus sequence.
  initial begin
    int rr_all[5];
    int rr_odd[5];
    int esc_at[$];
    int oc;
    logic gv_ok;
    int ack_den;
    logic [N_S-1:0] c, x;
    rr_all = '{0, 1, 2, 3, 0};
    rr_odd = '{1, 3, 1, 0, 0};
    modelReset();

    // Reset then idle for 20 cycles.
    doReset();
    for (int i = 0; i < 20; i++) applyStimulus('0, '0, 1'b0, 1'b0);
    checkOutput("idle_outputs", int'(dutVec()), 0);

    // Single call with full handshake.
    doReset();
    applyStimulus(4'b0100, '0, 1'b0, 1'b0);
    checkOutput("single_pending_c1", int'(pending), 4'b0100);
    applyStimulus('0, '0, 1'b0, 1'b0);
    checkOutput("single_gv_c2", int'(grant_valid), 1);
    checkOutput("single_gid_c2", int'(grant_id), 2);
    applyStimulus('0, '0, 1'b0, 1'b0);
    applyStimulus('0, '0, 1'b1, 1'b0);
    checkOutput("single_busy_c4", int'(busy), 1);
    applyStimulus('0, '0, 1'b0, 1'b0);
    applyStimulus('0, '0, 1'b0, 1'b0);
    applyStimulus('0, '0, 1'b0, 1'b1);
    checkOutput("single_pending_c7", int'(pending[2]), 0);
    checkOutput("single_busy_c7", int'(busy), 0);

    // Round-robin over all four stations, then over stations 1 and 3.
    doReset();
    runRotation(4'b1111, rr_all, 5, "rr_all");
    doReset();
    runRotation(4'b1010, rr_odd, 3, "rr_odd");

    // Cancel during an offer withdraws it; call beats cancel in the same cycle.
    doReset();
    applyStimulus(4'b0010, '0, 1'b0, 1'b0);
    applyStimulus('0, '0, 1'b0, 1'b0);
    checkOutput("cancel_offer_gv", int'(grant_valid), 1);
    applyStimulus('0, 4'b0010, 1'b0, 1'b0);
    checkOutput("cancel_pending", int'(pending[1]), 0);
    applyStimulus('0, '0, 1'b0, 1'b0);
    checkOutput("cancel_gv_drop", int'(grant_valid), 0);
    checkOutput("cancel_no_busy", int'(busy), 0);
    applyStimulus(4'b0010, 4'b0010, 1'b0, 1'b0);
    checkOutput("call_beats_cancel", int'(pending[1]), 1);

    // Timeout escalation on an unanswered offer.
    doReset();
    applyStimulus(4'b0001, '0, 1'b0, 1'b0);
    oc    = -1;
    gv_ok = 1'b1;
    for (int i = 0; i < 44; i++) begin
      applyStimulus('0, '0, 1'b0, 1'b0);
      if (grant_valid) oc = (oc < 0) ? 0 : oc + 1;
      else if (oc >= 0) gv_ok = 1'b0;
      if (escalate) esc_at.push_back(oc);
    end
    checkOutput("esc_count", esc_at.size(), 2);
    checkOutput("esc_first", (esc_at.size() > 0) ? esc_at[0] : -1, 16);
    checkOutput("esc_second", (esc_at.size() > 1) ? esc_at[1] : -1, 32);
    checkOutput("esc_gv_held", int'(gv_ok), 1);

    // Randomized traffic with alternating attentive and sluggish attendants.
    doReset();
    for (int phase = 0; phase < 6; phase++) begin
      ack_den = (phase % 2 == 1) ? 20 : 2;
      for (int i = 0; i < 500; i++) begin
        c = ($urandom_range(0, 3) == 0) ? N_S'($urandom) : '0;
        x = ($urandom_range(0, 7) == 0) ? N_S'($urandom) : '0;
        applyStimulus(c, x, ($urandom_range(0, ack_den - 1) == 0),
                      ($urandom_range(0, 3) == 0));
      end
    end

    // Reset in the middle of a service, then a fresh call is granted.
    doReset();
    applyStimulus(4'b1011, '0, 1'b0, 1'b0);
    applyStimulus('0, '0, 1'b0, 1'b0);
    applyStimulus('0, '0, 1'b1, 1'b0);
    checkOutput("mid_serve_busy", int'(busy), 1);
    checkOutput("mid_serve_pending", int'(pending), 4'b1011);
    doReset();
    applyStimulus(4'b1000, '0, 1'b0, 1'b0);
    for (int i = 0; i < 5 && !grant_valid; i++) applyStimulus('0, '0, 1'b0, 1'b0);
    checkOutput("post_reset_gv", int'(grant_valid), 1);
    checkOutput("post_reset_gid", int'(grant_id), 3);

    @(negedge clk);
    #2;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
